// File: rtl/parking_pkg.sv
// Shared types and constants for the two-beam parking gate.
package parking_pkg;
  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3} gate_state_t;

  localparam int CAP_DEFAULT = 16;

  // Sensor pattern {a, b}
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;
endpackage

// File: rtl/parking_lot_controller_sync2.sv
// Two-flop synchronizer for one asynchronous gate sensor.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/parking_lot_controller.sv
// Parking gate sequencer: decodes beam-break order into enter/exit pulses
// and keeps a saturating occupancy count with full/empty flags.
module parking_lot_controller
  import parking_pkg::*;
#(
  parameter int CAP = CAP_DEFAULT,
  parameter int CW  = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a,
  input  logic          b,
  output logic          enter,
  output logic          exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam logic [CW-1:0] CAP_W = CW'(CAP);

  logic        a_s, b_s;
  logic [1:0]  ab_s;
  gate_state_t state, state_nxt;
  logic        enter_nxt, exit_nxt;

  sync2 u_sync_a (.clk(clk), .reset(reset), .d(a), .q(a_s));
  sync2 u_sync_b (.clk(clk), .reset(reset), .d(b), .q(b_s));

  assign ab_s = {a_s, b_s};

  // Entry walks 10 -> 11 -> 01 -> 00; exit is the same walk with a/b swapped.
  // Any step that skips a stage aborts back to IDLE silently.
  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ab_s == AB_A)      state_nxt = IN1;
        else if (ab_s == AB_B) state_nxt = OUT1;
      end
      IN1: begin
        case (ab_s)
          AB_A:    state_nxt = IN1;
          AB_BOTH: state_nxt = IN2;
          default: state_nxt = IDLE;
        endcase
      end
      IN2: begin
        case (ab_s)
          AB_BOTH: state_nxt = IN2;
          AB_B:    state_nxt = IN3;
          AB_A:    state_nxt = IN1;
          default: state_nxt = IDLE;
        endcase
      end
      IN3: begin
        case (ab_s)
          AB_B:    state_nxt = IN3;
          AB_BOTH: state_nxt = IN2;
          AB_NONE: begin
            state_nxt = IDLE;
            enter_nxt = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
      OUT1: begin
        case (ab_s)
          AB_B:    state_nxt = OUT1;
          AB_BOTH: state_nxt = OUT2;
          default: state_nxt = IDLE;
        endcase
      end
      OUT2: begin
        case (ab_s)
          AB_BOTH: state_nxt = OUT2;
          AB_A:    state_nxt = OUT3;
          AB_B:    state_nxt = OUT1;
          default: state_nxt = IDLE;
        endcase
      end
      OUT3: begin
        case (ab_s)
          AB_A:    state_nxt = OUT3;
          AB_BOTH: state_nxt = OUT2;
          AB_NONE: begin
            state_nxt = IDLE;
            exit_nxt  = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      enter <= enter_nxt;
      exit  <= exit_nxt;
      // Saturate at both ends; pulses still fire even when count cannot move.
      if (enter && count < CAP_W)
        count <= count + 1'b1;
      else if (exit && count != '0)
        count <= count - 1'b1;
    end
  end

  assign full  = (count == CAP_W);
  assign empty = (count == '0);
endmodule
